// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus write sequencer feeding a UART transmitter, paced on Tx_BUSY.
// Define UART_TX_FEEDER_OVF_FLAG_EN to build the sticky overflow flag.
module uart_tx_feeder #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              tx_enable,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ack_err,
    output logic              overflow,
    output logic [7:0]        Tx_DATA,
    output logic              Tx_WR,
    output logic              Tx_EN,
    input  logic              Tx_BUSY
);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [TMR_W-1:0]  timer;
    logic              push, pop;

    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign Tx_EN = tx_enable;
    assign push  = wr_en && !full;
    assign pop   = (state == IDLE) && !empty && tx_enable && !Tx_BUSY;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // A byte whose write is never acknowledged is dropped after the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            Tx_DATA <= 8'h00;
            Tx_WR   <= 1'b0;
            timer   <= '0;
            ack_err <= 1'b0;
        end else begin
            ack_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        Tx_DATA <= mem[rd_ptr];
                        Tx_WR   <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    Tx_WR <= 1'b0;
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (Tx_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMR_LAST) begin
                        ack_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!Tx_BUSY) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (wr_en && full)
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model, transmitter responder,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_feeder;
    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 16;

    logic       clk = 0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en, tx_enable;
    logic       full, empty, ack_err, overflow, Tx_WR, Tx_EN;
    logic [3:0] count;
    logic [7:0] Tx_DATA;
    logic       Tx_BUSY;
    logic       xbusy, force_busy;

    assign Tx_BUSY = xbusy | force_busy;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(3), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
        .tx_enable(tx_enable), .full(full), .empty(empty), .count(count),
        .ack_err(ack_err), .overflow(overflow), .Tx_DATA(Tx_DATA),
        .Tx_WR(Tx_WR), .Tx_EN(Tx_EN), .Tx_BUSY(Tx_BUSY)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;
    logic [7:0] rx_log[$];

`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    logic [7:0] m_data;
    bit m_wr, m_ack, m_ovf, m_idle, m_got_busy;
    int m_t;

    task automatic model_reset();
        mq.delete();
        m_data = 8'h00; m_wr = 0; m_ack = 0; m_ovf = 0;
        m_idle = 1; m_got_busy = 0; m_t = 0;
    endtask

    // One clock edge worth of behaviour, from the inputs seen just before the edge.
    task automatic model_step();
        bit busy, do_pop, do_push;
        int n;
        busy    = Tx_BUSY;
        n       = mq.size();
        do_pop  = m_idle && n > 0 && tx_enable && !busy;
        do_push = wr_en && n < DEPTH;
        m_ack   = 0;
        if (wr_en && n == DEPTH && OVF_EN) m_ovf = 1;
        if (m_idle) begin
            if (do_pop) begin
                m_data = mq.pop_front();
                m_wr = 1; m_idle = 0; m_t = 0; m_got_busy = 0;
            end
        end else begin
            m_t++;
            m_wr = 0;
            if (!m_got_busy) begin
                // busy is only looked at from the second cycle after issue
                if (m_t >= 2) begin
                    if (busy) m_got_busy = 1;
                    else if (m_t == ACK_TIMEOUT + 1) begin
                        m_ack = 1; m_idle = 1;
                    end
                end
            end else if (!busy) begin
                m_idle = 1;
            end
        end
        if (do_push) mq.push_back(wr_data);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset && chk_on) begin
                chk("count",    int'(count),    mq.size());
                chk("empty",    int'(empty),    int'(mq.size() == 0));
                chk("full",     int'(full),     int'(mq.size() == DEPTH));
                chk("Tx_WR",    int'(Tx_WR),    int'(m_wr));
                chk("Tx_DATA",  int'(Tx_DATA),  int'(m_data));
                chk("ack_err",  int'(ack_err),  int'(m_ack));
                chk("overflow", int'(overflow), int'(m_ovf));
                chk("Tx_EN",    int'(Tx_EN),    int'(tx_enable));
                if (Tx_WR) rx_log.push_back(Tx_DATA);
            end
        end
    end

    // ---------------- transmitter responder ----------------
    int resp_dly = 1, resp_frame = 10;
    bit resp_ignore = 0;

    initial begin
        xbusy = 0;
        forever begin
            step();
            if (Tx_WR && !resp_ignore) begin
                repeat (resp_dly) step();
                xbusy = 1;
                repeat (resp_frame) step();
                xbusy = 0;
            end
        end
    end

    task automatic push(input logic [7:0] d);
        wr_en = 1; wr_data = d;
        step();
        wr_en = 0;
    endtask

    task automatic wait_log(input int target, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (rx_log.size() >= target) break;
            step();
        end
        chk(nm, int'(rx_log.size() >= target), 1);
    endtask

    task automatic wait_wr(input int budget, input string nm);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (Tx_WR) begin seen = 1; break; end
            step();
        end
        chk(nm, int'(seen), 1);
    endtask

    int base;

    initial begin
        reset = 0; wr_en = 0; wr_data = 8'h00; tx_enable = 1; force_busy = 0;
        repeat (3) step();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full), 0);
        chk("rst_Tx_WR", int'(Tx_WR), 0);
        chk("rst_Tx_DATA", int'(Tx_DATA), 0);
        chk("rst_ack_err", int'(ack_err), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(negedge clk); #2; reset = 1; chk_on = 1;
        step();

        // 1: single byte, latency and pop
        resp_dly = 1; resp_frame = 10;
        wr_en = 1; wr_data = 8'hA5;
        step(); wr_en = 0;
        chk("t1_empty_after_write", int'(empty), 0);
        chk("t1_no_wr_yet", int'(Tx_WR), 0);
        step();
        chk("t1_wr", int'(Tx_WR), 1);
        chk("t1_data", int'(Tx_DATA), 8'hA5);
        chk("t1_empty_after_pop", int'(empty), 1);
        step();
        chk("t1_wr_one_cycle", int'(Tx_WR), 0);
        repeat (20) step();

        // 2: fill with transmitter busy, overflow, drain in order
        resp_frame = 4;
        force_busy = 1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        chk("t2_full", int'(full), 1);
        chk("t2_count", int'(count), 8);
        push(8'h09);
        chk("t2_count_after_drop", int'(count), 8);
        chk("t2_overflow", int'(overflow), int'(OVF_EN));
        base = rx_log.size();
        force_busy = 0;
        wait_log(base + 8, 200, "t2_drain_timeout");
        for (int i = 0; i < 8; i++)
            if (base + i < rx_log.size()) chk("t2_order", int'(rx_log[base + i]), i + 1);
        repeat (10) step();

        // 3: push and pop on the same edge at count=3
        force_busy = 1;
        push(8'h11); push(8'h22); push(8'h33);
        step();
        base = rx_log.size();
        force_busy = 0; wr_en = 1; wr_data = 8'h44;
        step(); wr_en = 0;
        chk("t3_count", int'(count), 3);
        chk("t3_wr", int'(Tx_WR), 1);
        chk("t3_data", int'(Tx_DATA), 8'h11);
        wait_log(base + 4, 200, "t3_drain_timeout");
        if (rx_log.size() >= base + 4) begin
            chk("t3_ord1", int'(rx_log[base + 1]), 8'h22);
            chk("t3_ord2", int'(rx_log[base + 2]), 8'h33);
            chk("t3_ord3", int'(rx_log[base + 3]), 8'h44);
        end
        repeat (10) step();

        // 4: no acknowledge from the transmitter
        resp_ignore = 1;
        push(8'h55); push(8'h66);
        wait_wr(20, "t4_wr_timeout");
        chk("t4_data0", int'(Tx_DATA), 8'h55);
        repeat (16) step();
        chk("t4_ack_early", int'(ack_err), 0);
        step();
        chk("t4_ack", int'(ack_err), 1);
        step();
        chk("t4_ack_pulse", int'(ack_err), 0);
        chk("t4_next_wr", int'(Tx_WR), 1);
        chk("t4_data1", int'(Tx_DATA), 8'h66);
        repeat (20) step();
        resp_ignore = 0;
        repeat (5) step();

        // 5: transmit enable gating
        tx_enable = 0;
        base = rx_log.size();
        push(8'h71); push(8'h72);
        repeat (10) step();
        chk("t5_held", rx_log.size(), base);
        chk("t5_count", int'(count), 2);
        resp_frame = 6;
        tx_enable = 1;
        wait_log(base + 2, 100, "t5_send_timeout");
        if (rx_log.size() >= base + 2) begin
            chk("t5_b0", int'(rx_log[base]), 8'h71);
            chk("t5_b1", int'(rx_log[base + 1]), 8'h72);
        end
        repeat (10) step();
        base = rx_log.size();
        push(8'h73); push(8'h74);
        wait_wr(20, "t5_wr_timeout");
        tx_enable = 0;
        repeat (30) step();
        chk("t5_one_sent", rx_log.size(), base + 1);
        chk("t5_last", int'(rx_log[rx_log.size() - 1]), 8'h73);
        chk("t5_left", int'(count), 1);

        // 6: reset while a frame is on the line
        resp_frame = 20;
        tx_enable = 1;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        step(); step();
        chk("t6_count_before", int'(count), 4);
        @(negedge clk); #2; reset = 0; #1;
        chk("t6_wr_in_reset", int'(Tx_WR), 0);
        chk("t6_count_in_reset", int'(count), 0);
        chk("t6_empty_in_reset", int'(empty), 1);
        @(negedge clk); #2; reset = 1;
        base = rx_log.size();
        repeat (40) step();
        chk("t6_no_wr_after_reset", rx_log.size(), base);
        push(8'h99);
        wait_log(base + 1, 50, "t6_new_timeout");
        if (rx_log.size() > base) chk("t6_new_byte", int'(rx_log[base]), 8'h99);
        repeat (30) step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            wr_en       = ($urandom % 100) < 40;
            wr_data     = 8'($urandom);
            tx_enable   = ($urandom % 100) < 92;
            resp_ignore = ($urandom % 12) == 0;
            resp_dly    = 1 + int'($urandom % 3);
            resp_frame  = 1 + int'($urandom % 8);
            step();
        end
        wr_en = 0; tx_enable = 1; resp_ignore = 0;
        repeat (150) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
